// File: rtl/bitfusion_pkg.sv
// ----------------------------------------------------------------------------
// bitfusion_pkg
// Shared definitions for the Bit Fusion MAC processing element:
//   BF_W2/BF_W4/BF_W8  lane width codes as they appear on cfg_*_width
//   bf_state_e         PE control states
//   bf_width_legal()   true when a width code is one of the fusable widths
// ----------------------------------------------------------------------------
package bitfusion_pkg;

    localparam logic [3:0] BF_W2 = 4'd2;
    localparam logic [3:0] BF_W4 = 4'd4;
    localparam logic [3:0] BF_W8 = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } bf_state_e;

    function automatic logic bf_width_legal(input logic [3:0] w);
        return (w == BF_W2) || (w == BF_W4) || (w == BF_W8);
    endfunction

endpackage

// File: rtl/bitfusion_dot_unit.sv
// ----------------------------------------------------------------------------
// bitfusion_dot_unit
// Combinational fused-lane dot product: splits both operand words into
// lanes of LW = max(iw, ww) bits, keeps the low iw/ww bits of each lane,
// sign- or zero-extends them, multiplies lane-wise and sums the products.
// Ports:
//   in_data_i  [IN_W]   packed input lanes, lane 0 at LSBs
//   w_data_i   [IN_W]   packed weight lanes, lane 0 at LSBs
//   iw_i, ww_i [4]      input / weight lane width code (2, 4 or 8)
//   s_in_i, s_w_i       operand signedness
//   dot_o      [ACC_W]  dot product, two's complement, truncated to ACC_W
// ----------------------------------------------------------------------------
module bitfusion_dot_unit
    import bitfusion_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32
) (
    input  logic [IN_W-1:0]         in_data_i,
    input  logic [IN_W-1:0]         w_data_i,
    input  logic [3:0]              iw_i,
    input  logic [3:0]              ww_i,
    input  logic                    s_in_i,
    input  logic                    s_w_i,
    output logic signed [ACC_W-1:0] dot_o
);

    localparam int MAX_LANES = IN_W / 2;
    // Headroom so the lane sum never overflows before the final truncation.
    localparam int SUM_W = ACC_W + 16;

    // Keep the low w bits of a lane and widen to a 10-bit signed operand,
    // wide enough for both -128 and +255.
    function automatic logic signed [9:0] ext_op(input logic [7:0] raw,
                                                 input logic [3:0] w,
                                                 input logic       s);
        case (w)
            BF_W2:   return s ? {{8{raw[1]}}, raw[1:0]} : {8'b0, raw[1:0]};
            BF_W4:   return s ? {{6{raw[3]}}, raw[3:0]} : {6'b0, raw[3:0]};
            default: return s ? {{2{raw[7]}}, raw}      : {2'b0, raw};
        endcase
    endfunction

    logic [3:0]              lw;
    logic [7:0]              a_raw;
    logic [7:0]              b_raw;
    logic signed [19:0]      prod;
    logic signed [SUM_W-1:0] sum;

    assign lw = (iw_i > ww_i) ? iw_i : ww_i;

    always_comb begin
        a_raw = '0;
        b_raw = '0;
        prod  = '0;
        sum   = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            // Only IN_W/LW lanes exist for the current fusion width.
            if (k * int'(lw) < IN_W) begin
                a_raw = 8'(in_data_i >> (k * int'(lw)));
                b_raw = 8'(w_data_i  >> (k * int'(lw)));
                prod  = ext_op(a_raw, iw_i, s_in_i) * ext_op(b_raw, ww_i, s_w_i);
                sum   = sum + SUM_W'(prod);
            end
        end
        dot_o = sum[ACC_W-1:0];
    end

endmodule

// File: rtl/bitfusion_mac_pe.sv
// ----------------------------------------------------------------------------
// bitfusion_mac_pe
// Bit Fusion processing element: configurable 2/4/8-bit fused lanes,
// streaming dot-product accumulation over cfg_len beats, result on a
// valid/ready port. Sits between operand buffers and the psum collector.
// Build option: BITFUSION_SAT_EN defined -> accumulation saturates (sticky
// for the rest of the job); undefined -> accumulation wraps mod 2^ACC_W.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        configuration handshake (ready only in IDLE)
//   cfg_in_width/_weight_width lane widths 2, 4 or 8
//   cfg_s_in/cfg_s_weight      operand signedness
//   cfg_len                    beats per accumulation (>= 1)
//   cfg_err                    one-cycle pulse on a rejected configuration
//   in_valid/in_ready          operand beat handshake (ready only in RUN)
//   in_data/weight_data        packed lanes, lane 0 at LSBs
//   out_valid/out_ready        result handshake, out_psum held while stalled
//   out_psum                   accumulated result
//   busy                       high whenever not IDLE
// ----------------------------------------------------------------------------
module bitfusion_mac_pe
    import bitfusion_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_in_width,
    input  logic [3:0]       cfg_weight_width,
    input  logic             cfg_s_in,
    input  logic             cfg_s_weight,
    input  logic [CNT_W-1:0] cfg_len,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [IN_W-1:0]  weight_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_psum,
    output logic             busy
);

    bf_state_e               state_q;
    logic [3:0]              iw_q, ww_q;
    logic                    s_in_q, s_w_q;
    logic [CNT_W-1:0]        len_q, cnt_q, cnt_d;
    logic                    cfg_err_q, out_valid_q;
    logic                    vld_p0_q, vld_p1_q;
    logic [IN_W-1:0]         in_p0_q, w_p0_q;
    logic signed [ACC_W-1:0] dot_p0, dot_p1_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sat_q, sat_d;
    logic                    accept, cfg_ok;

    assign accept    = in_valid && (state_q == RUN);
    assign in_ready  = (state_q == RUN);
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_psum  = acc_q;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign cfg_ok    = bf_width_legal(cfg_in_width) && bf_width_legal(cfg_weight_width)
                       && (cfg_len != '0);

`ifdef BITFUSION_SAT_EN
    // Returns {clamped, value}. Signed overflow shows as the two top bits of
    // the extended sum disagreeing; unsigned overflow as a carry out.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b,
                                               input logic                    sgn);
        logic [ACC_W:0] s;
        logic [ACC_W:0] u;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        u = {1'b0, a} + {1'b0, b};
        if (sgn) begin
            if (s[ACC_W] != s[ACC_W-1])
                return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            return {1'b0, s[ACC_W-1:0]};
        end
        if (u[ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, u[ACC_W-1:0]};
    endfunction

    // Once clamped, the accumulator is frozen until the result is taken.
    always_comb begin
        if (sat_q) {sat_d, acc_d} = {1'b1, acc_q};
        else       {sat_d, acc_d} = sat_add(acc_q, dot_p1_q, s_in_q | s_w_q);
    end
`else
    always_comb begin
        acc_d = acc_q + dot_p1_q;
        sat_d = sat_q;
    end
`endif

    bitfusion_dot_unit #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_dot (
        .in_data_i (in_p0_q),
        .w_data_i  (w_p0_q),
        .iw_i      (iw_q),
        .ww_i      (ww_q),
        .s_in_i    (s_in_q),
        .s_w_i     (s_w_q),
        .dot_o     (dot_p0)
    );

    // Stage p0: operand capture on accept; stage p1: dot-product register.
    always_ff @(posedge clk) begin
        if (accept) begin
            in_p0_q <= in_data;
            w_p0_q  <= weight_data;
        end
        if (vld_p0_q) dot_p1_q <= dot_p0;
    end

    // Stage p2: accumulate; control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iw_q        <= BF_W8;
            ww_q        <= BF_W8;
            s_in_q      <= 1'b0;
            s_w_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            vld_p0_q  <= accept;
            vld_p1_q  <= vld_p0_q;
            if (vld_p1_q) begin
                acc_q <= acc_d;
                sat_q <= sat_d;
            end
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_ok) begin
                            iw_q    <= cfg_in_width;
                            ww_q    <= cfg_weight_width;
                            s_in_q  <= cfg_s_in;
                            s_w_q   <= cfg_s_weight;
                            len_q   <= cfg_len;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last beat is in p1 now and lands in acc_q on this edge.
                    if (!vld_p0_q) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        sat_q       <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitfusion_mac_pe.sv
// ----------------------------------------------------------------------------
// tb_bitfusion_mac_pe
// Two PE instances (ACC_W=32 and ACC_W=16) driven by the same stimulus and
// compared against an arithmetic reference of the fused-lane dot product.
// ----------------------------------------------------------------------------
module tb_bitfusion_mac_pe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [3:0]  cfg_in_width, cfg_weight_width;
    logic        cfg_s_in, cfg_s_weight;
    logic [15:0] cfg_len;
    logic        in_valid;
    logic [7:0]  in_data, weight_data;
    logic        out_ready;

    logic        cfg_ready, cfg_err, in_ready, out_valid, busy;
    logic [31:0] out_psum;
    logic        cfg_ready_b, cfg_err_b, in_ready_b, out_valid_b, busy_b;
    logic [15:0] out_psum_b;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last32, last16;

    always #5 clk = ~clk;

    bitfusion_mac_pe #(.IN_W(8), .ACC_W(32), .CNT_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .weight_data(weight_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .busy(busy)
    );

    bitfusion_mac_pe #(.IN_W(8), .ACC_W(16), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
        .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight), .cfg_len(cfg_len),
        .cfg_err(cfg_err_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .weight_data(weight_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_psum(out_psum_b),
        .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference dot product straight from the lane rule.
    function automatic longint dot_ref(input logic [7:0] a8, input logic [7:0] b8,
                                       input int iw, input int ww, input bit si, input bit sw);
        int     lw, a, b;
        longint s;
        s  = 0;
        lw = (iw > ww) ? iw : ww;
        for (int k = 0; k < 8 / lw; k++) begin
            a = (int'(a8) >> (k * lw)) & ((1 << iw) - 1);
            b = (int'(b8) >> (k * lw)) & ((1 << ww) - 1);
            if (si && a >= (1 << (iw - 1))) a -= (1 << iw);
            if (sw && b >= (1 << (ww - 1))) b -= (1 << ww);
            s += longint'(a * b);
        end
        return s;
    endfunction

    function automatic void acc_step(inout longint acc, inout bit stuck, input longint d,
                                     input int w, input bit sgn);
`ifdef BITFUSION_SAT_EN
        longint hi, lo;
        hi = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        lo = sgn ? -(longint'(1) << (w - 1)) : 0;
        if (!stuck) begin
            acc += d;
            if (acc > hi)      begin acc = hi; stuck = 1'b1; end
            else if (acc < lo) begin acc = lo; stuck = 1'b1; end
        end
`else
        acc  += d;
        stuck = 1'b0;
`endif
    endfunction

    function automatic int pick_w();
        case ($urandom_range(0, 2))
            0:       return 2;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    task automatic run_job(input int iw, input int ww, input bit si, input bit sw,
                           input int len, input bit rnd, input logic [7:0] fin,
                           input logic [7:0] fw, input int stall, input bit gaps);
        longint e32, e16, d;
        bit     st32, st16, take;
        int     acc_cnt, cyc, n;
        e32 = 0; e16 = 0; st32 = 0; st16 = 0; acc_cnt = 0; cyc = 0;
        cfg_in_width     = 4'(iw);
        cfg_weight_width = 4'(ww);
        cfg_s_in         = si;
        cfg_s_weight     = sw;
        cfg_len          = 16'(len);
        cfg_valid        = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("cfg_busy", 64'(busy), 64'd1);
        check("cfg_in_ready", 64'(in_ready), 64'd1);
        while (acc_cnt < len && cyc < 500) begin
            in_valid    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data     = rnd ? 8'($urandom) : fin;
            weight_data = rnd ? 8'($urandom) : fw;
            take        = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (take) begin
                d = dot_ref(in_data, weight_data, iw, ww, si, sw);
                acc_step(e32, st32, d, 32, si | sw);
                acc_step(e16, st16, d, 16, si | sw);
                acc_cnt++;
            end
        end
        in_valid = 1'b0;
        if (acc_cnt < len) check("accept_timeout", 64'(acc_cnt), 64'(len));
        check("drain_in_ready", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'd2);
        check("psum32", 64'(out_psum), 64'(e32) & 64'hFFFF_FFFF);
        check("valid16", 64'(out_valid_b), 64'd1);
        check("psum16", 64'(out_psum_b), 64'(e16) & 64'hFFFF);
        last32 = 64'(out_psum);
        last16 = 64'(out_psum_b);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_psum", 64'(out_psum), 64'(e32) & 64'hFFFF_FFFF);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 64'(out_valid), 64'd0);
        check("post_cfg_ready", 64'(cfg_ready), 64'd1);
        check("post_psum", 64'(out_psum), 64'd0);
    endtask

    task automatic try_bad_cfg(input logic [3:0] iw, input logic [15:0] len);
        cfg_in_width     = iw;
        cfg_weight_width = 4'd8;
        cfg_len          = len;
        cfg_valid        = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("bad_cfg_err", 64'(cfg_err), 64'd1);
        check("bad_cfg_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("bad_cfg_pulse", 64'(cfg_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_in_width = 4'd8; cfg_weight_width = 4'd8;
        cfg_s_in = 1'b0; cfg_s_weight = 1'b0; cfg_len = 16'd1; in_valid = 1'b0;
        in_data = '0; weight_data = '0; out_ready = 1'b0;
        #12;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_psum", 64'(out_psum), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 8x8 signed: -1 * 2
        run_job(8, 8, 1, 1, 1, 0, 8'hFF, 8'h02, 0, 0);
        check("t1_psum", last32, 64'hFFFF_FFFE);
        // 4x4 unsigned, two beats of 22
        run_job(4, 4, 0, 0, 2, 0, 8'h32, 8'h45, 1, 1);
        check("t2_psum", last32, 64'd44);
        // 2x2 unsigned, three beats of 36, stalled output
        run_job(2, 2, 0, 0, 3, 0, 8'hFF, 8'hFF, 5, 0);
        check("t3_psum", last32, 64'd108);
        // Mixed 2x8 signed: -1 * 5
        run_job(2, 8, 1, 1, 1, 0, 8'h03, 8'h05, 0, 0);
        check("t4_psum", last32, 64'hFFFF_FFFB);
        try_bad_cfg(4'd3, 16'd1);
        try_bad_cfg(4'd8, 16'd0);
        // 2 * (-128 * -128) overflows a 16-bit signed accumulator
        run_job(8, 8, 1, 1, 2, 0, 8'h80, 8'h80, 0, 0);
        check("t5_psum32", last32, 64'd32768);
`ifdef BITFUSION_SAT_EN
        check("t5_psum16", last16, 64'h7FFF);
`else
        check("t5_psum16", last16, 64'h8000);
`endif

        // Abort mid-job; cfg offers while running must be ignored.
        cfg_in_width = 4'd8; cfg_weight_width = 4'd8; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
        cfg_len = 16'd4; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_in_width = 4'd3;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("run_cfg_no_err", 64'(cfg_err), 64'd0);
        check("run_cfg_busy", 64'(busy), 64'd1);
        in_valid = 1'b1; in_data = 8'h01; weight_data = 8'h01;
        repeat (2) @(posedge clk);
        #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        #2;
        check("abort_psum", 64'(out_psum), 64'd0);
        check("abort_psum16", 64'(out_psum_b), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_cfg_ready", 64'(cfg_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(8, 8, 0, 0, 1, 0, 8'h01, 8'h01, 0, 0);
        check("t6_psum", last32, 64'd1);

        for (int j = 0; j < 25; j++)
            run_job(pick_w(), pick_w(), 1'($urandom), 1'($urandom),
                    int'($urandom_range(1, 6)), 1'b1, 8'h00, 8'h00,
                    int'($urandom_range(0, 3)), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
